// File: rtl/shared_pkg.sv
// Shared constants for the FIFO read path.
// BUS_WIDTH     : data word width shared by the synchronous FIFO and its readers.
// BURST_LEN_DEF : default number of beats per output burst.
// OUT_DEPTH_DEF : default output buffer depth of the burst reader.
package shared_pkg;

  localparam int unsigned BUS_WIDTH     = 8;
  localparam int unsigned BURST_LEN_DEF = 4;
  localparam int unsigned OUT_DEPTH_DEF = 3;

endpackage

// File: rtl/out_buffer.sv
// Small circular output buffer with push/pop/count interface.
// Ports:
//   CLK, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail
//   push_data   : word to store
//   pop         : drop the head entry (caller guarantees count != 0)
//   head_data   : entry at the read pointer
//   count       : number of stored entries, 0..DEPTH
module out_buffer #(
  parameter int unsigned WIDTH = shared_pkg::BUS_WIDTH,
  parameter int unsigned DEPTH = shared_pkg::OUT_DEPTH_DEF
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Pointers wrap at DEPTH-1, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero while empty after reset.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pulls words from a synchronous FIFO (one-cycle read latency) into a small
// output buffer and presents them as valid/ready bursts of BURST_LEN beats.
// Ports:
//   CLK, rst_n    : clock, asynchronous active-low reset
//   fifo_rd_en    : read request to upstream FIFO
//   fifo_bus_out  : FIFO read data, qualified by fifo_valid
//   fifo_valid    : FIFO read data qualifier
//   fifo_empty    : FIFO empty flag
//   m_data        : head of output buffer
//   m_valid       : output word present
//   m_ready       : downstream accept
//   m_last        : current beat is the last of its burst
//   proto_err     : sticky, FIFO returned data that was never requested
module fifo_burst_reader #(
  parameter int unsigned BUS_WIDTH = shared_pkg::BUS_WIDTH,
  parameter int unsigned BURST_LEN = shared_pkg::BURST_LEN_DEF,
  parameter int unsigned OUT_DEPTH = shared_pkg::OUT_DEPTH_DEF
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  output logic                 fifo_rd_en,
  input  logic [BUS_WIDTH-1:0] fifo_bus_out,
  input  logic                 fifo_valid,
  input  logic                 fifo_empty,
  output logic [BUS_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 proto_err
);

  localparam int unsigned BeatW = $clog2(BURST_LEN) + 1;
  localparam int unsigned CntW  = $clog2(OUT_DEPTH + 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

  logic             run_q;
  logic             inflight_q, inflight_d;
  logic             proto_err_q, proto_err_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [CntW-1:0]  count;
  logic             push, pop;

  out_buffer #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_out_buffer (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_bus_out),
    .pop       (pop),
    .head_data (m_data),
    .count     (count)
  );

  always_comb begin
    // Reserve a slot for the in-flight word so a push can never overflow.
    // run_q holds reads off until the first edge after reset release.
    fifo_rd_en  = run_q && !fifo_empty && ((32'(count) + 32'(inflight_q)) < OUT_DEPTH);
    push        = fifo_valid && inflight_q;
    proto_err_d = proto_err_q || (fifo_valid && !inflight_q);
    // A new read in the same cycle as returning data keeps one word in flight.
    if (fifo_rd_en)      inflight_d = 1'b1;
    else if (fifo_valid) inflight_d = 1'b0;
    else                 inflight_d = inflight_q;

    m_valid = (count != '0);
    pop     = m_valid && m_ready;
    m_last  = m_valid && (beat_q == LastBeat);
    beat_d  = beat_q;
    if (pop) beat_d = (beat_q == LastBeat) ? '0 : beat_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      inflight_q  <= 1'b0;
      proto_err_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      run_q       <= 1'b1;
      inflight_q  <= inflight_d;
      proto_err_q <= proto_err_d;
      beat_q      <= beat_d;
    end
  end

  assign proto_err = proto_err_q;

endmodule
